// File: rtl/exe_alu_stage.sv
// ---------------------------------------------------------------------------
// exe_alu_stage
//
// Execute stage of an ARM-style 5-stage pipeline. Combines the Rn operand
// (Val1) with the output of the Val2 generator under a 4-bit EXE_CMD opcode,
// derives the NZCV flags, keeps the architectural status register (SR), and
// registers the result plus passthrough control into the EXE/MEM register.
//
// Ports:
//   clk, rst_n          pipeline clock (rising edge), async active-low reset
//   freeze              hazard stall, every register holds
//   flush               branch flush, a bubble is inserted
//   valid_in            an instruction is present at the input
//   Val1, Val2          ALU operands (Rn and generated Val2)
//   Val_Rm_in           store data, passed through
//   EXE_CMD, S          ALU opcode and "update SR" request
//   WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in   passthrough control
//   ALU_Res, Val_Rm_out, Dest_out, WB_EN, MEM_R_EN, MEM_W_EN, valid_out
//                       registered EXE/MEM outputs
//   SR                  registered status {N,Z,C,V}
//   C_in                combinational copy of the current SR carry
//   exe_count           (EXE_PERF_CNT_EN only) count of valid loads
//
// Optional feature macro: EXE_PERF_CNT_EN adds the 32-bit exe_count output,
// which counts edges where the pipeline loads with valid_in=1.
// ---------------------------------------------------------------------------
module exe_alu_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     Val1,
  input  logic [DATA_W-1:0]     Val2,
  input  logic [DATA_W-1:0]     Val_Rm_in,
  input  logic [3:0]            EXE_CMD,
  input  logic                  S,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  output logic [DATA_W-1:0]     ALU_Res,
  output logic [DATA_W-1:0]     Val_Rm_out,
  output logic [REG_ADDR_W-1:0] Dest_out,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic                  valid_out,
  output logic [3:0]            SR,
`ifdef EXE_PERF_CNT_EN
  output logic [31:0]           exe_count,
`endif
  output logic                  C_in
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   add_ext;
  logic [DATA_W:0]   sub_ext;
  logic              add_cin;
  logic              sub_bin;
  logic [DATA_W-1:0] alu_res;
  logic              flag_n;
  logic              flag_z;
  logic              flag_c;
  logic              flag_v;
  logic              load;

  assign C_in = SR[1];

  // ADC adds the current carry; SBC subtracts the inverted carry (ARM
  // "not borrow" convention). Both adders are evaluated at DATA_W+1 bits so
  // the top bit yields carry/borrow directly.
  assign add_cin = (EXE_CMD == CMD_ADC) ? SR[1] : 1'b0;
  assign sub_bin = (EXE_CMD == CMD_SBC) ? ~SR[1] : 1'b0;

  assign add_ext = {1'b0, Val1} + {1'b0, Val2} + {{DATA_W{1'b0}}, add_cin};
  assign sub_ext = {1'b0, Val1} - {1'b0, Val2} - {{DATA_W{1'b0}}, sub_bin};

  // Result selection. Logic ops, moves and unknown codes leave C and V at
  // their current SR values; only arithmetic recomputes them.
  always_comb begin
    alu_res = '0;
    flag_c  = SR[1];
    flag_v  = SR[0];
    unique case (EXE_CMD)
      CMD_MOV: alu_res = Val2;
      CMD_MVN: alu_res = ~Val2;
      CMD_ADD, CMD_ADC: begin
        alu_res = add_ext[DATA_W-1:0];
        flag_c  = add_ext[DATA_W];
        flag_v  = (Val1[MSB] == Val2[MSB]) && (add_ext[MSB] != Val1[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        alu_res = sub_ext[DATA_W-1:0];
        flag_c  = ~sub_ext[DATA_W];
        flag_v  = (Val1[MSB] != Val2[MSB]) && (sub_ext[MSB] != Val1[MSB]);
      end
      CMD_AND: alu_res = Val1 & Val2;
      CMD_ORR: alu_res = Val1 | Val2;
      CMD_EOR: alu_res = Val1 ^ Val2;
      default: alu_res = '0;
    endcase
  end

  assign flag_n = alu_res[MSB];
  assign flag_z = (alu_res == '0);

  // A normal load happens only when neither flush nor freeze is active.
  assign load = ~flush & ~freeze;

  // EXE/MEM pipeline register. Flush beats freeze: a bubble clears the
  // control bits and zeroes the data fields. Control only propagates for a
  // valid instruction so an empty slot can never write back or touch memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Res    <= '0;
      Val_Rm_out <= '0;
      Dest_out   <= '0;
      WB_EN      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      valid_out  <= 1'b0;
    end else if (flush) begin
      ALU_Res    <= '0;
      Val_Rm_out <= '0;
      Dest_out   <= '0;
      WB_EN      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      valid_out  <= 1'b0;
    end else if (!freeze) begin
      ALU_Res    <= alu_res;
      Val_Rm_out <= Val_Rm_in;
      Dest_out   <= Dest_in;
      WB_EN      <= valid_in & WB_EN_in;
      MEM_R_EN   <= valid_in & MEM_R_EN_in;
      MEM_W_EN   <= valid_in & MEM_W_EN_in;
      valid_out  <= valid_in;
    end
  end

  // Status register: only a valid S-instruction on a loading edge updates
  // it, so the next instruction (e.g. a back-to-back ADC) sees these flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SR <= 4'b0000;
    end else if (load && valid_in && S) begin
      SR <= {flag_n, flag_z, flag_c, flag_v};
    end
  end

`ifdef EXE_PERF_CNT_EN
  // Counts instructions that actually entered EXE/MEM; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_count <= 32'd0;
    end else if (load && valid_in) begin
      exe_count <= exe_count + 32'd1;
    end
  end
`endif

endmodule
